// File: rtl/axi4_lite_slave_timer.sv
// axi4_lite_slave_timer: AXI4-Lite slave hosting a 64-bit prescaled timer.
// The timer has a 64-bit compare, a sticky match flag and a level interrupt.
// The slave stays silent on the shared bus outside its 32-byte window.
module axi4_lite_slave_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h2001_0000
) (
    input  logic        s_axi_aclk_i,
    input  logic        s_axi_areset_i,
    input  logic [31:0] s_axi_araddr_i,
    input  logic        s_axi_arvalid_i,
    output logic        s_axi_arready_o,
    input  logic        s_axi_rready_i,
    output logic        s_axi_rvalid_o,
    output logic [31:0] s_axi_rdata_o,
    input  logic [31:0] s_axi_awaddr_i,
    input  logic        s_axi_awvalid_i,
    output logic        s_axi_awready_o,
    input  logic [31:0] s_axi_wdata_i,
    input  logic [3:0]  s_axi_wstrb_i,
    input  logic        s_axi_wvalid_i,
    output logic        s_axi_wready_o,
    input  logic        s_axi_bready_i,
    output logic        s_axi_bvalid_o,
    input  logic [3:0]  read_size_i,
    output logic        irq_o
);

    localparam logic [2:0] ADDR_CTRL     = 3'd0;
    localparam logic [2:0] ADDR_PRESCALE = 3'd1;
    localparam logic [2:0] ADDR_CNT_LO   = 3'd2;
    localparam logic [2:0] ADDR_CNT_HI   = 3'd3;
    localparam logic [2:0] ADDR_CMP_LO   = 3'd4;
    localparam logic [2:0] ADDR_CMP_HI   = 3'd5;
    localparam logic [2:0] ADDR_STATUS   = 3'd6;

    typedef enum logic {RIdle, RData} rstate_e;
    typedef enum logic [1:0] {WIdle, WData, WResp} wstate_e;

    rstate_e     r_rstate;
    rstate_e     w_rstate_nxt;
    wstate_e     r_wstate;
    wstate_e     w_wstate_nxt;

    logic [31:0] r_rdata;
    logic [31:0] r_shadow;
    logic [2:0]  r_waddr;

    logic [1:0]  r_ctrl;
    logic [31:0] r_prescale;
    logic [31:0] r_psc;
    logic [63:0] r_cnt;
    logic [63:0] r_cmp;
    logic        r_match;

    logic        w_ar_hit;
    logic        w_aw_hit;
    logic        w_ar_fire;
    logic        w_aw_fire;
    logic        w_w_fire;
    logic        w_tick;
    logic [31:0] w_rd_mux;
    logic [63:0] w_cnt_nxt;
    logic        w_match_nxt;
    logic        w_unused;

    // Address bits below word granularity and the read size carry no information here.
    assign w_unused = ^{read_size_i, s_axi_araddr_i[1:0], s_axi_awaddr_i[1:0]};

    function automatic logic [31:0] f_merge(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

    // Window decode and handshake qualifiers; nothing is accepted while reset is held.
    always_comb begin
        w_ar_hit  = (s_axi_araddr_i[31:5] == BASE_ADDR[31:5]);
        w_aw_hit  = (s_axi_awaddr_i[31:5] == BASE_ADDR[31:5]);
        w_ar_fire = (r_rstate == RIdle) && s_axi_arvalid_i && w_ar_hit && !s_axi_areset_i;
        w_aw_fire = (r_wstate == WIdle) && s_axi_awvalid_i && w_aw_hit && !s_axi_areset_i;
        w_w_fire  = (r_wstate == WData) && s_axi_wvalid_i && !s_axi_areset_i;
    end

    // Read FSM state register.
    always_ff @(posedge s_axi_aclk_i) begin
        if (s_axi_areset_i) r_rstate <= RIdle;
        else                r_rstate <= w_rstate_nxt;
    end

    // Read FSM next state.
    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            RIdle:   if (w_ar_fire) w_rstate_nxt = RData;
            RData:   if (s_axi_rready_i) w_rstate_nxt = RIdle;
            default: w_rstate_nxt = RIdle;
        endcase
    end

    // Read FSM outputs; rdata is forced to 0 outside the data beat.
    always_comb begin
        s_axi_arready_o = w_ar_fire;
        s_axi_rvalid_o  = (r_rstate == RData);
        s_axi_rdata_o   = (r_rstate == RData) ? r_rdata : 32'd0;
    end

    // Register read mux; CNT_HI returns the shadow taken by the last CNT_LO read.
    always_comb begin
        case (s_axi_araddr_i[4:2])
            ADDR_CTRL:     w_rd_mux = {30'd0, r_ctrl};
            ADDR_PRESCALE: w_rd_mux = r_prescale;
            ADDR_CNT_LO:   w_rd_mux = r_cnt[31:0];
            ADDR_CNT_HI:   w_rd_mux = r_shadow;
            ADDR_CMP_LO:   w_rd_mux = r_cmp[31:0];
            ADDR_CMP_HI:   w_rd_mux = r_cmp[63:32];
            ADDR_STATUS:   w_rd_mux = {31'd0, r_match};
            default:       w_rd_mux = 32'd0;
        endcase
    end

    // Capture read data at AR acceptance and snapshot the upper count on CNT_LO reads.
    always_ff @(posedge s_axi_aclk_i) begin
        if (s_axi_areset_i) begin
            r_rdata  <= 32'd0;
            r_shadow <= 32'd0;
        end else if (w_ar_fire) begin
            r_rdata <= w_rd_mux;
            if (s_axi_araddr_i[4:2] == ADDR_CNT_LO) r_shadow <= r_cnt[63:32];
        end
    end

    // Write FSM state register plus the latched word offset.
    always_ff @(posedge s_axi_aclk_i) begin
        if (s_axi_areset_i) begin
            r_wstate <= WIdle;
            r_waddr  <= 3'd0;
        end else begin
            r_wstate <= w_wstate_nxt;
            if (w_aw_fire) r_waddr <= s_axi_awaddr_i[4:2];
        end
    end

    // Write FSM next state.
    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            WIdle:   if (w_aw_fire) w_wstate_nxt = WData;
            WData:   if (w_w_fire) w_wstate_nxt = WResp;
            WResp:   if (s_axi_bready_i) w_wstate_nxt = WIdle;
            default: w_wstate_nxt = WIdle;
        endcase
    end

    // Write FSM outputs.
    always_comb begin
        s_axi_awready_o = w_aw_fire;
        s_axi_wready_o  = (r_wstate == WData) && !s_axi_areset_i;
        s_axi_bvalid_o  = (r_wstate == WResp);
    end

    // Prescaler tick: counter reached PRESCALE while enabled.
    always_comb begin
        w_tick = r_ctrl[0] && (r_psc == r_prescale);
    end

    // Prescale counter; held at 0 while the timer is disabled.
    always_ff @(posedge s_axi_aclk_i) begin
        if (s_axi_areset_i || !r_ctrl[0] || w_tick) r_psc <= 32'd0;
        else                                        r_psc <= r_psc + 32'd1;
    end

    // Next count: a software write drops that cycle's increment for both halves.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_w_fire && (r_waddr == ADDR_CNT_LO)) begin
            w_cnt_nxt[31:0] = f_merge(r_cnt[31:0], s_axi_wdata_i, s_axi_wstrb_i);
        end else if (w_w_fire && (r_waddr == ADDR_CNT_HI)) begin
            w_cnt_nxt[63:32] = f_merge(r_cnt[63:32], s_axi_wdata_i, s_axi_wstrb_i);
        end else if (w_tick) begin
            w_cnt_nxt = r_cnt + 64'd1;
        end
    end

    // Sticky match; a live compare hit beats a same-cycle W1C.
    always_comb begin
        w_match_nxt = r_match;
        if (w_w_fire && (r_waddr == ADDR_STATUS) && s_axi_wstrb_i[0] && s_axi_wdata_i[0]) begin
            w_match_nxt = 1'b0;
        end
        if (r_cnt == r_cmp) w_match_nxt = 1'b1;
    end

    // Software-visible register file.
    always_ff @(posedge s_axi_aclk_i) begin
        if (s_axi_areset_i) begin
            r_ctrl     <= 2'd0;
            r_prescale <= 32'd0;
            r_cnt      <= 64'd0;
            r_cmp      <= {64{1'b1}};
            r_match    <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_match <= w_match_nxt;
            if (w_w_fire) begin
                case (r_waddr)
                    ADDR_CTRL:     if (s_axi_wstrb_i[0]) r_ctrl <= s_axi_wdata_i[1:0];
                    ADDR_PRESCALE: r_prescale <= f_merge(r_prescale, s_axi_wdata_i, s_axi_wstrb_i);
                    ADDR_CMP_LO:   r_cmp[31:0] <= f_merge(r_cmp[31:0], s_axi_wdata_i,
                                                          s_axi_wstrb_i);
                    ADDR_CMP_HI:   r_cmp[63:32] <= f_merge(r_cmp[63:32], s_axi_wdata_i,
                                                           s_axi_wstrb_i);
                    default:       ;
                endcase
            end
        end
    end

    // Interrupt is a plain level of the flag gated by irq_en.
    always_comb begin
        irq_o = r_match && r_ctrl[1];
    end

endmodule

// File: tb/tb_axi4_lite_slave_timer.sv
// Self-checking bench for axi4_lite_slave_timer: reset/register table, timer
// sequences, bus corner cases and a randomized register-file run against a model.
module tb_axi4_lite_slave_timer;

    localparam logic [31:0] BASE = 32'h2001_0000;

    logic        clk = 1'b0;
    logic        areset;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic        rready;
    logic        rvalid;
    logic [31:0] rdata;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic        bready;
    logic        bvalid;
    logic [3:0]  read_size;
    logic        irq;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    int unsigned g_wr_cyc;
    int unsigned g_rd_cyc;
    logic        g_irq_after_w;
    int          bad;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axi4_lite_slave_timer #(.BASE_ADDR(BASE)) dut (
        .s_axi_aclk_i    (clk),
        .s_axi_areset_i  (areset),
        .s_axi_araddr_i  (araddr),
        .s_axi_arvalid_i (arvalid),
        .s_axi_arready_o (arready),
        .s_axi_rready_i  (rready),
        .s_axi_rvalid_o  (rvalid),
        .s_axi_rdata_o   (rdata),
        .s_axi_awaddr_i  (awaddr),
        .s_axi_awvalid_i (awvalid),
        .s_axi_awready_o (awready),
        .s_axi_wdata_i   (wdata),
        .s_axi_wstrb_i   (wstrb),
        .s_axi_wvalid_i  (wvalid),
        .s_axi_wready_o  (wready),
        .s_axi_bready_i  (bready),
        .s_axi_bvalid_o  (bvalid),
        .read_size_i     (read_size),
        .irq_o           (irq)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input longint act, input longint lo,
                             input longint hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                           input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        areset = 1'b1;
        arvalid = 1'b0; rready = 1'b0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
        repeat (2) @(negedge clk);
        areset = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] off, output logic [31:0] data);
        int n;
        @(negedge clk);
        araddr = BASE + {27'd0, off};
        arvalid = 1'b1;
        rready = 1'b0;
        #1;
        n = 0;
        while (!arready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("ar_latency", 64'(n), 64'd0);
        if (n >= 20) begin
            arvalid = 1'b0;
            data = 32'hDEAD_BEEF;
            return;
        end
        // Keep arvalid high one more cycle: arready must still be a single pulse.
        @(negedge clk);
        rready = 1'b1;
        g_rd_cyc = cyc;
        #1;
        chk("ar_pulse", 64'(arready), 64'd0);
        chk("r_latency", 64'(rvalid), 64'd1);
        data = rdata;
        @(negedge clk);
        arvalid = 1'b0;
        rready = 1'b0;
        #1;
        chk("r_done", 64'(rvalid), 64'd0);
    endtask

    task automatic axi_write(input logic [4:0] off, input logic [31:0] data,
                             input logic [3:0] strb, input int bdelay);
        int n;
        @(negedge clk);
        awaddr = BASE + {27'd0, off};
        awvalid = 1'b1;
        #1;
        n = 0;
        while (!awready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("aw_latency", 64'(n), 64'd0);
        if (n >= 20) begin
            awvalid = 1'b0;
            return;
        end
        @(negedge clk);
        awvalid = 1'b0;
        wdata = data;
        wstrb = strb;
        wvalid = 1'b1;
        #1;
        chk("w_ready", 64'(wready), 64'd1);
        @(negedge clk);
        wvalid = 1'b0;
        g_wr_cyc = cyc;
        #1;
        g_irq_after_w = irq;
        chk("b_valid", 64'(bvalid), 64'd1);
        for (int i = 0; i < bdelay; i++) begin
            @(negedge clk); #1;
            chk("b_hold", 64'(bvalid), 64'd1);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        #1;
        chk("b_done", 64'(bvalid), 64'd0);
    endtask

    typedef struct {
        logic        wr;
        logic [4:0]  off;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        longint      ticks;
        logic        seen;
        logic [1:0]  m_ctrl;
        logic [31:0] m_pre;
        logic [63:0] m_cnt;
        logic [63:0] m_cmp;
        logic        m_match;
        logic [31:0] m_shadow;
        logic [31:0] exp;

        areset = 1'b1;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        read_size = 4'd2;
        repeat (3) @(negedge clk);
        areset = 1'b0;
        #1;
        chk("reset_outputs", 64'({arready, rvalid, rdata, awready, wready, bvalid, irq}), 64'd0);

        // Reset values, reserved bits, byte strobes and write-ignored offsets.
        vecs.push_back('{1'b0, 5'h00, 32'h0,         4'h0, 32'h0000_0000});
        vecs.push_back('{1'b0, 5'h04, 32'h0,         4'h0, 32'h0000_0000});
        vecs.push_back('{1'b0, 5'h08, 32'h0,         4'h0, 32'h0000_0000});
        vecs.push_back('{1'b0, 5'h0C, 32'h0,         4'h0, 32'h0000_0000});
        vecs.push_back('{1'b0, 5'h10, 32'h0,         4'h0, 32'hFFFF_FFFF});
        vecs.push_back('{1'b0, 5'h14, 32'h0,         4'h0, 32'hFFFF_FFFF});
        vecs.push_back('{1'b0, 5'h18, 32'h0,         4'h0, 32'h0000_0000});
        vecs.push_back('{1'b0, 5'h1C, 32'h0,         4'h0, 32'h0000_0000});
        vecs.push_back('{1'b1, 5'h04, 32'h1234_5678, 4'hF, 32'h0});
        vecs.push_back('{1'b0, 5'h04, 32'h0,         4'h0, 32'h1234_5678});
        vecs.push_back('{1'b1, 5'h04, 32'hAABB_CCDD, 4'h5, 32'h0});
        vecs.push_back('{1'b0, 5'h04, 32'h0,         4'h0, 32'h12BB_56DD});
        vecs.push_back('{1'b1, 5'h00, 32'hFFFF_FFFE, 4'hF, 32'h0});
        vecs.push_back('{1'b0, 5'h00, 32'h0,         4'h0, 32'h0000_0002});
        vecs.push_back('{1'b1, 5'h1C, 32'hFFFF_FFFF, 4'hF, 32'h0});
        vecs.push_back('{1'b0, 5'h1C, 32'h0,         4'h0, 32'h0000_0000});
        vecs.push_back('{1'b1, 5'h18, 32'h0000_0001, 4'hF, 32'h0});
        vecs.push_back('{1'b0, 5'h18, 32'h0,         4'h0, 32'h0000_0000});
        vecs.push_back('{1'b1, 5'h00, 32'h0,         4'hF, 32'h0});
        vecs.push_back('{1'b1, 5'h04, 32'h0,         4'hF, 32'h0});
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr) begin
                axi_write(vecs[i].off, vecs[i].data, vecs[i].strb, 0);
            end else begin
                axi_read(vecs[i].off, d);
                chk($sformatf("vec%0d_rd", i), 64'(d), 64'(vecs[i].exp));
            end
        end
        chk("irq_idle", 64'(irq), 64'd0);

        // Prescale 3: one count every 4 cycles; bready held off for 5 cycles.
        axi_write(5'h04, 32'd3, 4'hF, 5);
        axi_write(5'h00, 32'd1, 4'hF, 0);
        ticks = longint'(g_wr_cyc);
        repeat (40) @(negedge clk);
        axi_read(5'h08, d);
        ticks = (longint'(g_rd_cyc) - ticks - 1) / 4;
        chk_range("cnt_prescale", longint'(d), ticks - 1, ticks + 1);
        chk_range("cnt_prescale_10", longint'(d), 9, 13);
        axi_read(5'h0C, d);
        chk("cnt_hi_shadow0", 64'(d), 64'd0);

        // Low-word wrap with PRESCALE=0, then atomic high-word read via the shadow.
        axi_write(5'h00, 32'd0, 4'hF, 0);
        axi_write(5'h08, 32'hFFFF_FFFF, 4'hF, 0);
        axi_write(5'h0C, 32'd0, 4'hF, 0);
        axi_write(5'h04, 32'd0, 4'hF, 0);
        axi_write(5'h00, 32'd1, 4'hF, 0);
        ticks = longint'(g_wr_cyc);
        repeat (4) @(negedge clk);
        axi_read(5'h08, d);
        ticks = longint'(g_rd_cyc) - ticks - 1;
        chk_range("wrap_lo", longint'(d), ticks - 2, ticks);
        axi_read(5'h0C, d);
        chk("wrap_hi_shadow", 64'(d), 64'd1);
        axi_write(5'h00, 32'd0, 4'hF, 0);
        axi_write(5'h0C, 32'd5, 4'hF, 0);
        axi_read(5'h0C, d);
        chk("hi_last_shadow", 64'(d), 64'd1);

        // Compare match at 20 with prescale 3, then W1C.
        axi_write(5'h08, 32'd0, 4'hF, 0);
        axi_write(5'h0C, 32'd0, 4'hF, 0);
        axi_write(5'h14, 32'd0, 4'hF, 0);
        axi_write(5'h10, 32'd20, 4'hF, 0);
        axi_write(5'h04, 32'd3, 4'hF, 0);
        axi_write(5'h18, 32'd1, 4'hF, 0);
        axi_read(5'h18, d);
        chk("status_before", 64'(d), 64'd0);
        axi_write(5'h00, 32'd3, 4'hF, 0);
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk); #1;
            if (irq) seen = 1'b1;
        end
        chk("irq_rise", 64'(seen), 64'd1);
        axi_read(5'h08, d);
        chk("cnt_at_match", 64'(d), 64'd20);
        axi_read(5'h18, d);
        chk("status_set", 64'(d), 64'd1);
        axi_write(5'h00, 32'd2, 4'hF, 0);
        chk("irq_sticky", 64'(g_irq_after_w), 64'd1);
        axi_write(5'h18, 32'd1, 4'hF, 0);
        chk("irq_w1c", 64'(g_irq_after_w), 64'd0);
        axi_read(5'h18, d);
        chk("status_clr", 64'(d), 64'd0);

        // Out-of-window read stays silent while an in-window write completes.
        bad = 0;
        fork
            begin
                @(negedge clk);
                araddr = BASE + 32'h40;
                arvalid = 1'b1;
                for (int i = 0; i < 20; i++) begin
                    #1;
                    if (arready || rvalid) bad++;
                    @(negedge clk);
                end
                arvalid = 1'b0;
            end
            axi_write(5'h14, 32'h1234_5678, 4'hF, 1);
        join
        chk("miss_silent", 64'(bad), 64'd0);
        axi_read(5'h14, d);
        chk("cmp_hi_concurrent", 64'(d), 64'h1234_5678);
        @(negedge clk);
        awaddr = BASE + 32'h20;
        awvalid = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (awready || wready || bvalid) bad++;
            @(negedge clk);
        end
        awvalid = 1'b0;
        chk("aw_miss_silent", 64'(bad), 64'd0);

        // Single-byte strobe into CMP_LO.
        axi_write(5'h10, 32'hFFFF_FFFF, 4'hF, 0);
        axi_write(5'h10, 32'hAABB_CCDD, 4'b0010, 0);
        axi_read(5'h10, d);
        chk("wstrb_byte1", 64'(d), 64'hFFFF_CCFF);

        // Reset while the read data beat is pending.
        @(negedge clk);
        araddr = BASE + 32'h14;
        arvalid = 1'b1;
        rready = 1'b0;
        #1;
        chk("rst_ar", 64'(arready), 64'd1);
        @(negedge clk);
        arvalid = 1'b0;
        #1;
        chk("rst_rvalid_pre", 64'(rvalid), 64'd1);
        areset = 1'b1;
        @(negedge clk); #1;
        chk("rst_rvalid_drop", 64'({rvalid, rdata}), 64'd0);
        areset = 1'b0;
        axi_read(5'h14, d);
        chk("rst_cmp_hi", 64'(d), 64'hFFFF_FFFF);

        // Randomized register-file traffic with the timer disabled.
        do_reset();
        m_ctrl = 2'd0; m_pre = 32'd0; m_cnt = 64'd0; m_cmp = {64{1'b1}};
        m_match = 1'b0; m_shadow = 32'd0;
        for (int i = 0; i < 200; i++) begin
            logic [2:0]  off;
            logic [31:0] data;
            logic [3:0]  strb;
            off  = 3'($urandom_range(0, 7));
            data = $urandom;
            strb = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                if (off == 3'd0) data[0] = 1'b0;
                axi_write({off, 2'b00}, data, strb, int'($urandom_range(0, 2)));
                case (off)
                    3'd0: if (strb[0]) m_ctrl = data[1:0];
                    3'd1: m_pre = bmerge(m_pre, data, strb);
                    3'd2: m_cnt[31:0] = bmerge(m_cnt[31:0], data, strb);
                    3'd3: m_cnt[63:32] = bmerge(m_cnt[63:32], data, strb);
                    3'd4: m_cmp[31:0] = bmerge(m_cmp[31:0], data, strb);
                    3'd5: m_cmp[63:32] = bmerge(m_cmp[63:32], data, strb);
                    3'd6: if (strb[0] && data[0]) m_match = 1'b0;
                    default: ;
                endcase
                if (m_cnt == m_cmp) m_match = 1'b1;
            end else begin
                axi_read({off, 2'b00}, d);
                case (off)
                    3'd0: exp = {30'd0, m_ctrl};
                    3'd1: exp = m_pre;
                    3'd2: begin exp = m_cnt[31:0]; m_shadow = m_cnt[63:32]; end
                    3'd3: exp = m_shadow;
                    3'd4: exp = m_cmp[31:0];
                    3'd5: exp = m_cmp[63:32];
                    3'd6: exp = {31'd0, m_match};
                    default: exp = 32'd0;
                endcase
                chk($sformatf("rand%0d_rd_off%0d", i, off), 64'(d), 64'(exp));
            end
            chk($sformatf("rand%0d_irq", i), 64'(irq), 64'(m_match & m_ctrl[1]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
